// File: rtl/sram_rd_port_arbiter_pkg.sv
// Shared state encoding and width helpers for the SRAM read-port arbiter.
// Definitions only; no logic lives here.
package sram_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // Index widths never collapse to zero bits, even for a single port.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    localparam int NUM_OF_PORTS_DFLT = 16;
    localparam int PORT_IDX_W        = idx_width(NUM_OF_PORTS_DFLT);

endpackage

// File: rtl/sram_rd_port_arbiter_rr_pick.sv
// Rotating-priority pick: first requester at or after rr_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; pure function of req and rr_ptr.
module rr_pick
    import sram_arb_pkg::*;
#(
    parameter int N  = NUM_OF_PORTS_DFLT,
    parameter int PW = PORT_IDX_W
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [PW-1:0] winner,
    output logic          any
);
    localparam int SW = PW + 1;

    logic [SW-1:0] sum;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        sum    = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, rr_ptr} + SW'(i);
            if (sum >= SW'(N)) sum = sum - SW'(N);
            if (!any && req[sum[PW-1:0]]) begin
                any    = 1'b1;
                winner = sum[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/sram_rd_port_arbiter.sv
// Shares one SRAM read port among requesters with round-robin and packet lock.
// Latency: beat accepted at T -> sram_enb at T+1 -> rd_data/rd_vld at T+2+sram_latency.
// Backpressure: gnt is the ready; a beat moves only when req[p] & gnt[p]; returns are never stalled.
module sram_rd_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int num_of_ports       = 16,
    parameter int address_width      = 12,
    parameter int arbiter_data_width = 64,
    parameter int sram_latency       = 1,
    parameter int max_burst          = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [num_of_ports-1:0]               req,
    input  logic [num_of_ports*address_width-1:0] req_addr,
    input  logic [num_of_ports-1:0]               req_last,
    output logic [num_of_ports-1:0]               gnt,
    output logic                                  sram_enb,
    output logic [address_width-1:0]              sram_addr,
    input  logic [arbiter_data_width-1:0]         sram_dout,
    output logic [arbiter_data_width-1:0]         rd_data,
    output logic [num_of_ports-1:0]               rd_vld,
    output logic                                  busy
);
    localparam int PW    = idx_width(num_of_ports);
    localparam int CNT_W = idx_width(max_burst + 1);
    localparam int DEPTH = sram_latency + 1;

    localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]        CNT_MAX   = CNT_W'(max_burst);
    localparam logic [PW-1:0]           PORT_ONE  = PW'(1);
    localparam logic [PW-1:0]           LAST_PORT = PW'(num_of_ports - 1);
    localparam logic [num_of_ports-1:0] VEC_ONE   = num_of_ports'(1);

    typedef struct packed {
        logic          vld;
        logic [PW-1:0] owner;
    } tag_t;

    arb_state_t               state;
    logic [PW-1:0]            owner;
    logic [PW-1:0]            rr_ptr;
    logic [PW-1:0]            winner;
    logic                     any_req;
    logic [CNT_W-1:0]         beat_cnt;
    logic [CNT_W-1:0]         beat_cnt_nxt;
    logic                     accept;
    logic                     release_now;
    logic [address_width-1:0] owner_addr;
    tag_t                     pipe [DEPTH];

    rr_pick #(
        .N  (num_of_ports),
        .PW (PW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .any    (any_req)
    );

    // Owner dropping req ends the packet without consuming a beat.
    always_comb begin
        accept       = (state == BURST) && req[owner];
        beat_cnt_nxt = beat_cnt + CNT_ONE;
        owner_addr   = req_addr[owner*address_width +: address_width];
        release_now  = (state == BURST) &&
                       (!req[owner] || req_last[owner] ||
                        ((max_burst != 0) && (beat_cnt_nxt == CNT_MAX)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            gnt       <= '0;
            sram_enb  <= 1'b0;
            sram_addr <= '0;
            busy      <= 1'b0;
        end else begin
            sram_enb <= accept;
            if (accept) begin
                sram_addr <= owner_addr;
                beat_cnt  <= beat_cnt_nxt;
            end
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner    <= winner;
                        gnt      <= VEC_ONE << winner;
                        state    <= BURST;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                    end else begin
                        gnt <= '0;
                    end
                end
                BURST: begin
                    if (release_now) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= (owner == LAST_PORT) ? '0 : owner + PORT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Owner tag rides alongside the SRAM read so returns survive grant changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
            rd_vld  <= '0;
            rd_data <= '0;
        end else begin
            pipe[0] <= '{vld: accept, owner: owner};
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            rd_vld <= pipe[DEPTH-1].vld ? (VEC_ONE << pipe[DEPTH-1].owner) : '0;
            if (pipe[DEPTH-1].vld) rd_data <= sram_dout;
        end
    end

endmodule

// File: tb/tb_sram_rd_port_arbiter.sv
// Directed bench: instance a (latency 1, max_burst 4) and instance b (latency 3, unlimited burst).
`timescale 1ns/1ps
module tb_sram_rd_port_arbiter;
    localparam int N  = 16;
    localparam int AW = 12;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    req_a, last_a, gnt_a, vld_a, req_b, last_b, gnt_b, vld_b;
    logic [N*AW-1:0] raddr_a, raddr_b;
    logic            enb_a, enb_b, busy_a, busy_b;
    logic [AW-1:0]   saddr_a, saddr_b;
    logic [DW-1:0]   dout_a, dout_b, rdat_a, rdat_b, pipe_b1, pipe_b2;

    sram_rd_port_arbiter #(.sram_latency(1), .max_burst(4)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_addr(raddr_a), .req_last(last_a),
        .gnt(gnt_a), .sram_enb(enb_a), .sram_addr(saddr_a), .sram_dout(dout_a),
        .rd_data(rdat_a), .rd_vld(vld_a), .busy(busy_a)
    );

    sram_rd_port_arbiter #(.sram_latency(3), .max_burst(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_addr(raddr_b), .req_last(last_b),
        .gnt(gnt_b), .sram_enb(enb_b), .sram_addr(saddr_b), .sram_dout(dout_b),
        .rd_data(rdat_b), .rd_vld(vld_b), .busy(busy_b)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {4{4'hD, a}};
    endfunction

    // SRAM models: one-cycle and three-cycle read latency.
    always @(posedge clk) if (enb_a) dout_a <= mem_word(saddr_a);
    always @(posedge clk) begin
        pipe_b1 <= enb_b ? mem_word(saddr_b) : '0;
        pipe_b2 <= pipe_b1;
        dout_b  <= pipe_b2;
    end

    int            beats  [2][N];
    int            refill [2][N];
    logic [AW-1:0] nxt    [2][N];
    logic [N-1:0]  s_gnt  [2];
    logic [N-1:0]  s_vld  [2];
    logic          s_enb  [2];
    logic          s_busy [2];
    logic [AW-1:0] s_addr [2];
    logic [DW-1:0] s_data [2];
    int n_cmp = 0;
    int n_err = 0;

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            req_a[p]             = beats[0][p] > 0;
            last_a[p]            = beats[0][p] == 1;
            raddr_a[p*AW +: AW]  = nxt[0][p];
            req_b[p]             = beats[1][p] > 0;
            last_b[p]            = beats[1][p] == 1;
            raddr_b[p*AW +: AW]  = nxt[1][p];
        end
    endtask

    task automatic set_port(input int i, input int p, input int n, input logic [AW-1:0] a);
        beats[i][p] = n;
        nxt[i][p]   = a;
        drive();
    endtask

    // Sample one cycle at the falling edge, then advance the requester model.
    task automatic tick();
        logic [N-1:0] acc [2];
        @(negedge clk);
        s_gnt[0] = gnt_a; s_vld[0] = vld_a; s_enb[0] = enb_a; s_busy[0] = busy_a;
        s_addr[0] = saddr_a; s_data[0] = rdat_a;
        s_gnt[1] = gnt_b; s_vld[1] = vld_b; s_enb[1] = enb_b; s_busy[1] = busy_b;
        s_addr[1] = saddr_b; s_data[1] = rdat_b;
        acc[0] = req_a & gnt_a;
        acc[1] = req_b & gnt_b;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < N; p++)
                if (acc[i][p]) begin
                    beats[i][p]--;
                    nxt[i][p]++;
                    if (beats[i][p] == 0) beats[i][p] = refill[i][p];
                end
        drive();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < N; p++) begin
                beats[i][p] = 0; refill[i][p] = 0; nxt[i][p] = '0;
            end
        drive();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (s_gnt[i] !== '0) begin n_err++; $display("FAIL reset_gnt[%0d]: got %h want 0", i, s_gnt[i]); end
            n_cmp++; if (s_enb[i] !== 1'b0) begin n_err++; $display("FAIL reset_enb[%0d]: got %b want 0", i, s_enb[i]); end
            n_cmp++; if (s_addr[i] !== '0) begin n_err++; $display("FAIL reset_addr[%0d]: got %h want 0", i, s_addr[i]); end
            n_cmp++; if (s_vld[i] !== '0) begin n_err++; $display("FAIL reset_vld[%0d]: got %h want 0", i, s_vld[i]); end
            n_cmp++; if (s_data[i] !== '0) begin n_err++; $display("FAIL reset_data[%0d]: got %h want 0", i, s_data[i]); end
            n_cmp++; if (s_busy[i] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %b want 0", i, s_busy[i]); end
        end
    endtask

    task automatic test_single_packet();
        logic [N-1:0] e_gnt, e_vld;
        logic         e_enb;
        do_reset();
        set_port(0, 3, 4, 12'h010);
        for (int c = 0; c < 10; c++) begin
            tick();
            e_gnt = (c >= 1 && c <= 4) ? 16'h0008 : 16'h0000;
            e_enb = (c >= 2 && c <= 5);
            e_vld = (c >= 4 && c <= 7) ? 16'h0008 : 16'h0000;
            n_cmp++; if (s_gnt[0] !== e_gnt) begin n_err++; $display("FAIL single_gnt c%0d: got %h want %h", c, s_gnt[0], e_gnt); end
            n_cmp++; if (s_enb[0] !== e_enb) begin n_err++; $display("FAIL single_enb c%0d: got %b want %b", c, s_enb[0], e_enb); end
            if (e_enb) begin
                n_cmp++; if (s_addr[0] !== 12'h010 + AW'(c - 2)) begin n_err++; $display("FAIL single_addr c%0d: got %h want %h", c, s_addr[0], 12'h010 + AW'(c - 2)); end
            end
            n_cmp++; if (s_vld[0] !== e_vld) begin n_err++; $display("FAIL single_vld c%0d: got %h want %h", c, s_vld[0], e_vld); end
            if (e_vld != 0) begin
                n_cmp++; if (s_data[0] !== mem_word(12'h010 + AW'(c - 4))) begin n_err++; $display("FAIL single_data c%0d: got %h want %h", c, s_data[0], mem_word(12'h010 + AW'(c - 4))); end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [N-1:0] e_gnt, e_vld;
        do_reset();
        set_port(0, 5, 8, 12'h050);
        for (int c = 0; c < 4; c++) begin
            tick();
            e_gnt = (c >= 1) ? 16'h0020 : 16'h0000;
            n_cmp++; if (s_gnt[0] !== e_gnt) begin n_err++; $display("FAIL midrst_gnt c%0d: got %h want %h", c, s_gnt[0], e_gnt); end
        end
        set_port(0, 2, 2, 12'h020);
        set_port(0, 9, 2, 12'h090);
        rst = 1'b0;
        tick();
        n_cmp++; if (s_gnt[0] !== '0) begin n_err++; $display("FAIL midrst_gnt_in_reset: got %h want 0", s_gnt[0]); end
        n_cmp++; if (s_enb[0] !== 1'b0) begin n_err++; $display("FAIL midrst_enb_in_reset: got %b want 0", s_enb[0]); end
        n_cmp++; if (s_vld[0] !== '0) begin n_err++; $display("FAIL midrst_vld_in_reset: got %h want 0", s_vld[0]); end
        n_cmp++; if (s_busy[0] !== 1'b0) begin n_err++; $display("FAIL midrst_busy_in_reset: got %b want 0", s_busy[0]); end
        rst = 1'b1;
        for (int c = 5; c < 10; c++) begin
            tick();
            e_gnt = (c == 6 || c == 7) ? 16'h0004 : ((c == 9) ? 16'h0020 : 16'h0000);
            e_vld = (c == 9) ? 16'h0004 : 16'h0000;
            n_cmp++; if (s_gnt[0] !== e_gnt) begin n_err++; $display("FAIL midrst_regnt c%0d: got %h want %h", c, s_gnt[0], e_gnt); end
            n_cmp++; if (s_vld[0] !== e_vld) begin n_err++; $display("FAIL midrst_vld c%0d: got %h want %h", c, s_vld[0], e_vld); end
        end
        n_cmp++; if (s_data[0] !== mem_word(12'h020)) begin n_err++; $display("FAIL midrst_data: got %h want %h", s_data[0], mem_word(12'h020)); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] order [3];
        logic [N-1:0] e_gnt;
        order = '{16'h0001, 16'h0020, 16'h8000};
        do_reset();
        refill[0][0] = 2; refill[0][5] = 2; refill[0][15] = 2;
        set_port(0, 0, 2, 12'h000);
        set_port(0, 5, 2, 12'h050);
        set_port(0, 15, 2, 12'h0F0);
        for (int c = 0; c < 15; c++) begin
            tick();
            e_gnt = (c % 3 == 0) ? 16'h0000 : order[(c / 3) % 3];
            n_cmp++; if (s_gnt[0] !== e_gnt) begin n_err++; $display("FAIL rr_gnt c%0d: got %h want %h", c, s_gnt[0], e_gnt); end
            n_cmp++; if (s_busy[0] !== (e_gnt != 0)) begin n_err++; $display("FAIL rr_busy c%0d: got %b want %b", c, s_busy[0], e_gnt != 0); end
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] e_gnt;
        logic         e_enb;
        logic [AW-1:0] e_addr;
        do_reset();
        set_port(0, 14, 1, 12'h0E0);
        for (int c = 0; c < 7; c++) begin
            if (c == 2) begin
                set_port(0, 2, 1, 12'h020);
                set_port(0, 15, 1, 12'h0F0);
            end
            tick();
            e_gnt  = (c == 1) ? 16'h4000 : (c == 3) ? 16'h8000 : (c == 5) ? 16'h0004 : 16'h0000;
            e_enb  = (c == 2 || c == 4 || c == 6);
            e_addr = (c == 2) ? 12'h0E0 : (c == 4) ? 12'h0F0 : 12'h020;
            n_cmp++; if (s_gnt[0] !== e_gnt) begin n_err++; $display("FAIL wrap_gnt c%0d: got %h want %h", c, s_gnt[0], e_gnt); end
            n_cmp++; if (s_enb[0] !== e_enb) begin n_err++; $display("FAIL wrap_enb c%0d: got %b want %b", c, s_enb[0], e_enb); end
            if (e_enb) begin
                n_cmp++; if (s_addr[0] !== e_addr) begin n_err++; $display("FAIL wrap_addr c%0d: got %h want %h", c, s_addr[0], e_addr); end
            end
        end
    endtask

    task automatic test_max_burst();
        logic [AW-1:0] e_addr [17];
        logic [N-1:0]  e_gnt;
        e_addr = '{12'h000, 12'h000, 12'h100, 12'h101, 12'h102, 12'h103, 12'h000, 12'h010, 12'h011,
                   12'h000, 12'h104, 12'h105, 12'h106, 12'h107, 12'h000, 12'h108, 12'h109};
        do_reset();
        set_port(0, 7, 10, 12'h100);
        for (int c = 0; c < 17; c++) begin
            if (c == 1) set_port(0, 1, 2, 12'h010);
            tick();
            e_gnt = ((c >= 1 && c <= 4) || (c >= 9 && c <= 12) || c == 14 || c == 15) ? 16'h0080 :
                    (c == 6 || c == 7) ? 16'h0002 : 16'h0000;
            n_cmp++; if (s_gnt[0] !== e_gnt) begin n_err++; $display("FAIL maxb_gnt c%0d: got %h want %h", c, s_gnt[0], e_gnt); end
            n_cmp++; if (s_enb[0] !== (e_addr[c] != 0)) begin n_err++; $display("FAIL maxb_enb c%0d: got %b want %b", c, s_enb[0], e_addr[c] != 0); end
            if (e_addr[c] != 0) begin
                n_cmp++; if (s_addr[0] !== e_addr[c]) begin n_err++; $display("FAIL maxb_addr c%0d: got %h want %h", c, s_addr[0], e_addr[c]); end
            end
        end
    endtask

    task automatic test_abandon_latency();
        logic [N-1:0]  e_gnt, e_vld;
        logic          e_enb;
        logic [AW-1:0] e_addr, e_daddr;
        do_reset();
        set_port(1, 4, 20, 12'h200);
        set_port(1, 9, 1, 12'h300);
        for (int c = 0; c < 15; c++) begin
            if (c == 6) begin
                beats[1][4] = 0;
                drive();
            end
            tick();
            e_gnt   = (c >= 1 && c <= 6) ? 16'h0010 : (c == 8) ? 16'h0200 : 16'h0000;
            e_enb   = (c >= 2 && c <= 6) || (c == 9);
            e_addr  = (c == 9) ? 12'h300 : 12'h200 + AW'(c - 2);
            e_vld   = (c >= 6 && c <= 10) ? 16'h0010 : (c == 13) ? 16'h0200 : 16'h0000;
            e_daddr = (c == 13) ? 12'h300 : 12'h200 + AW'(c - 6);
            n_cmp++; if (s_gnt[1] !== e_gnt) begin n_err++; $display("FAIL lat_gnt c%0d: got %h want %h", c, s_gnt[1], e_gnt); end
            n_cmp++; if (s_enb[1] !== e_enb) begin n_err++; $display("FAIL lat_enb c%0d: got %b want %b", c, s_enb[1], e_enb); end
            if (e_enb) begin
                n_cmp++; if (s_addr[1] !== e_addr) begin n_err++; $display("FAIL lat_addr c%0d: got %h want %h", c, s_addr[1], e_addr); end
            end
            n_cmp++; if (s_vld[1] !== e_vld) begin n_err++; $display("FAIL lat_vld c%0d: got %h want %h", c, s_vld[1], e_vld); end
            if (e_vld != 0) begin
                n_cmp++; if (s_data[1] !== mem_word(e_daddr)) begin n_err++; $display("FAIL lat_data c%0d: got %h want %h", c, s_data[1], mem_word(e_daddr)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_reset_mid_burst();
        test_round_robin();
        test_wrap();
        test_max_burst();
        test_abandon_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_rd_port_arbiter.md
Name: sram_rd_port_arbiter

Overview:
- Shares one SRAM read port among num_of_ports per-port read arbiters; each read arbiter issues a request, a read address and a last flag per beat.
- Round-robin between requesters, with packet lock: a grant is held for a whole packet until the last beat, or until a max-burst limit is reached.
- Returns SRAM read data to the owning port with a one-hot valid, compensating for SRAM read latency.
- Sits between the read_arbiter instances and the SRAM bank read port.

Parameters:
- num_of_ports, 16: number of requesting read arbiters.
- address_width, 12: SRAM word address width.
- arbiter_data_width, 64: SRAM data width.
- sram_latency, 1: cycles from sram_enb to valid sram_dout; legal range 1..4.
- max_burst, 32: maximum beats per grant; 0 means unlimited.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  num_of_ports  per-port read request; held high while the port has beats to read.
- req_addr  in  num_of_ports*address_width  per-port read address; port p occupies bits [p*address_width +: address_width].
- req_last  in  num_of_ports  per-port flag: the current beat is the last of the packet.
- gnt  out  num_of_ports  one-hot grant (registered); a beat is accepted when req[p] & gnt[p].
- sram_enb  out  1  SRAM read enable (registered).
- sram_addr  out  address_width  SRAM read address (registered).
- sram_dout  in  arbiter_data_width  SRAM read data.
- rd_data  out  arbiter_data_width  returned data (registered).
- rd_vld  out  num_of_ports  one-hot: rd_data belongs to port p this cycle.
- busy  out  1  high in BURST state.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; gnt=0; sram_enb=0; sram_addr=0; rd_data=0; rd_vld=0; busy=0.
  - rr_ptr=0; beat counter=0; latency pipeline flushed.
  - Reset mid-burst drops all in-flight beats; no rd_vld is produced for them after reset.
- IDLE:
  - If |req, the winner is the first p with req[p]=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo num_of_ports.
  - Register owner=winner; next cycle gnt[owner]=1, state=BURST, beat counter=0.
  - If no request, stay in IDLE; gnt=0.
- BURST:
  - gnt stays one-hot on owner.
  - Accept occurs when req[owner]=1. On accept:
    - sram_enb=1 and sram_addr=req_addr[owner] on the next cycle;
    - beat counter increments.
  - A cycle with no accept drives sram_enb=0 on the next cycle.
  - Release (next state IDLE, gnt=0 next cycle, rr_ptr=(owner+1) mod num_of_ports) when any of:
    - accepted beat has req_last[owner]=1;
    - accepted beat brings the counter to max_burst (max_burst≠0);
    - req[owner]=0 (packet abandoned; no beat accepted that cycle).
  - Each release costs one IDLE arbitration cycle, so back-to-back packets have exactly one cycle with gnt=0.
- Data return:
  - Beat accepted at cycle T: sram_enb at T+1; sram_dout sampled at T+1+sram_latency; rd_data/rd_vld[owner] at T+2+sram_latency (T+3 with default latency).
  - Owner tag travels in a shift pipeline of depth sram_latency+1, so returns stay correct across grant changes.
- Fairness:
  - rr_ptr moves only on release; a port that just released has lowest priority next.
  - Single requester: re-granted after the one IDLE cycle.
- Widths: owner and rr_ptr are clog2(num_of_ports) bits; beat counter is clog2(max_burst+1) bits (min 1).
- Simultaneous events: last and max_burst on the same beat give a single release. req changes of non-owners during BURST are ignored.

Decomposition:
- Package sram_arb_pkg holds:
  - state encoding (IDLE, BURST);
  - clog2 function;
  - port-index width constant derived from num_of_ports.
- One sub-module, rr_pick: combinational rotating priority pick (req vector, rr_ptr -> winner index, any).
- The FSM, counter and latency pipeline stay in the top module.

Test Plan:
- Reset mid-burst: port 5 granted, 3 beats accepted, pull rst low for 1 cycle -> gnt=0, no rd_vld afterwards, next grant goes to the lowest requesting index from rr_ptr=0.
- Single packet: port 3 requests 4 beats at addresses 0x010–0x013, last on beat 4 -> gnt[3] from cycle 1; sram_addr 0x010..0x013 on consecutive cycles; rd_vld=16'h0008 for 4 cycles starting 3 cycles after the first accept; then gnt=0.
- Round-robin: ports 0, 5, 15 request 2-beat packets continuously -> grant order 0, 5, 15, 0, 5, ...; exactly one gnt=0 cycle between packets.
- Wrap: rr_ptr=15 after port 14 releases; ports 2 and 15 request -> port 15 wins, then port 2.
- max_burst=4: port 7 requests a 10-beat packet, port 1 also requesting -> port 7 released after 4 beats, port 1 granted, port 7 resumes later.
- Abandon and latency: owner drops req mid-packet -> release without an extra beat. With sram_latency=3, rd_vld arrives at T+5 and carries the correct owner tag across a grant switch.
